// File: rtl/vlsu_axi_order_ctrl.sv
// Issue gate between the VLSU address generator and the AXI AR/AW channels:
// caps outstanding bursts per direction, optional read/write exclusivity, fence drain.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal issue, subject to outstanding caps and ordering rules
// ST_DRAIN | fence seen: issue blocked, waiting for both counters to reach 0
// ST_ACK   | drain complete: one-cycle fence_ack_o, issue still blocked
module vlsu_axi_order_ctrl #(
  parameter int unsigned MaxOutstandingAr = 8,
  parameter int unsigned MaxOutstandingAw = 8,
  parameter int unsigned CntWidth =
    $clog2(((MaxOutstandingAr > MaxOutstandingAw) ? MaxOutstandingAr : MaxOutstandingAw) + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                strict_order_i,
  input  logic                ar_valid_i,
  output logic                ar_ready_o,
  output logic                ar_valid_o,
  input  logic                ar_ready_i,
  input  logic                aw_valid_i,
  output logic                aw_ready_o,
  output logic                aw_valid_o,
  input  logic                aw_ready_i,
  input  logic                r_valid_i,
  input  logic                r_ready_i,
  input  logic                r_last_i,
  input  logic                b_valid_i,
  input  logic                b_ready_i,
  input  logic                fence_req_i,
  output logic                fence_ack_o,
  output logic [CntWidth-1:0] ar_outstanding_o,
  output logic [CntWidth-1:0] aw_outstanding_o,
  output logic                idle_o,
  output logic                err_o
);

  localparam logic [CntWidth-1:0] LimAr = CntWidth'(MaxOutstandingAr);
  localparam logic [CntWidth-1:0] LimAw = CntWidth'(MaxOutstandingAw);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CntWidth-1:0] r_ar_cnt;
  logic [CntWidth-1:0] r_aw_cnt;
  logic [CntWidth-1:0] w_ar_cnt_nxt;
  logic [CntWidth-1:0] w_aw_cnt_nxt;
  logic                r_prio_w;
  logic                r_err;

  logic w_ar_fire;
  logic w_aw_fire;
  logic w_r_done;
  logic w_b_done;
  logic w_ar_uflow;
  logic w_aw_uflow;
  logic w_ar_zero;
  logic w_aw_zero;
  logic w_order_ar;
  logic w_order_aw;
  logic w_allow_ar;
  logic w_allow_aw;
  logic w_ack;
  logic w_prio_toggle;

  assign w_ar_zero = (r_ar_cnt == '0);
  assign w_aw_zero = (r_aw_cnt == '0);

  // Gates are forced low while reset is held so nothing escapes to AXI.
  assign ar_valid_o = ar_valid_i & w_allow_ar & ~rst_i;
  assign ar_ready_o = ar_ready_i & w_allow_ar & ~rst_i;
  assign aw_valid_o = aw_valid_i & w_allow_aw & ~rst_i;
  assign aw_ready_o = aw_ready_i & w_allow_aw & ~rst_i;
  assign fence_ack_o = w_ack & ~rst_i;

  assign w_ar_fire = ar_valid_o & ar_ready_i;
  assign w_aw_fire = aw_valid_o & aw_ready_i;
  assign w_r_done  = r_valid_i & r_ready_i & r_last_i;
  assign w_b_done  = b_valid_i & b_ready_i;

  always_comb begin
    w_ar_cnt_nxt = r_ar_cnt;
    w_ar_uflow   = 1'b0;
    unique case ({w_ar_fire, w_r_done})
      2'b10: w_ar_cnt_nxt = r_ar_cnt + CntOne;
      2'b01: begin
        if (w_ar_zero) w_ar_uflow = 1'b1;
        else           w_ar_cnt_nxt = r_ar_cnt - CntOne;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_aw_cnt_nxt = r_aw_cnt;
    w_aw_uflow   = 1'b0;
    unique case ({w_aw_fire, w_b_done})
      2'b10: w_aw_cnt_nxt = r_aw_cnt + CntOne;
      2'b01: begin
        if (w_aw_zero) w_aw_uflow = 1'b1;
        else           w_aw_cnt_nxt = r_aw_cnt - CntOne;
      end
      default: ;
    endcase
  end

  // With nothing in flight and both sides asking, prio_w picks a single winner.
  always_comb begin
    w_order_ar = 1'b1;
    w_order_aw = 1'b1;
    if (strict_order_i) begin
      if (w_ar_zero && w_aw_zero && ar_valid_i && aw_valid_i) begin
        w_order_ar = ~r_prio_w;
        w_order_aw = r_prio_w;
      end else begin
        w_order_ar = w_aw_zero;
        w_order_aw = w_ar_zero;
      end
    end
  end

  assign w_prio_toggle = strict_order_i &
                         ((~r_prio_w & w_ar_fire & aw_valid_i) |
                          ( r_prio_w & w_aw_fire & ar_valid_i));

  always_comb begin
    w_state_nxt = r_state;
    w_allow_ar  = 1'b0;
    w_allow_aw  = 1'b0;
    w_ack       = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (fence_req_i) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_allow_ar = (r_ar_cnt < LimAr) & w_order_ar;
          w_allow_aw = (r_aw_cnt < LimAw) & w_order_aw;
        end
      end
      ST_DRAIN: begin
        if ((w_ar_cnt_nxt == '0) && (w_aw_cnt_nxt == '0)) w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        w_ack       = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_RUN;
      r_ar_cnt <= '0;
      r_aw_cnt <= '0;
      r_prio_w <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ar_cnt <= w_ar_cnt_nxt;
      r_aw_cnt <= w_aw_cnt_nxt;
      if (w_prio_toggle) r_prio_w <= ~r_prio_w;
      if (w_ar_uflow || w_aw_uflow) r_err <= 1'b1;
    end
  end

  assign ar_outstanding_o = r_ar_cnt;
  assign aw_outstanding_o = r_aw_cnt;
  assign idle_o           = w_ar_zero & w_aw_zero & (r_state == ST_RUN);
  assign err_o            = r_err;

endmodule
